// File: rtl/sram_ctrl_param.sv
// sram_ctrl_param: MEM-stage SRAM controller. Splits one WORD_W-bit load or store
// into WORD_W/SRAM_DW beats on a narrower SRAM bus. Each beat lasts WAIT_CYC+1 cycles.
// ready is low while an access is in flight, and the pipeline freezes on ~ready.
module sram_ctrl_param #(
   parameter int WORD_W    = 32,
   parameter int SRAM_DW   = 16,
   parameter int SRAM_AW   = 18,
   parameter int WAIT_CYC  = 1,
   parameter int BASE_ADDR = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [WORD_W-1:0]  address,
   input  logic [WORD_W-1:0]  wr_data,
   output logic [WORD_W-1:0]  rd_data,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
);

   localparam int BEATS = WORD_W / SRAM_DW;
   localparam int WCW   = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
   localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t             state;
   logic [WCW-1:0]     wait_cnt;
   logic [BCW-1:0]     beat_cnt;
   logic               op_wr;
   logic [WORD_W-1:0]  wbuf;       // store data, shifted down one slice per beat
   logic [WORD_W-1:0]  rbuf;       // load assembly, slices enter at the top
   logic [SRAM_AW-1:0] word_idx;
   logic               beat_end;
   logic               last_beat;
   logic [WORD_W-1:0]  dq_ext;
   logic [WORD_W-1:0]  rd_next;

   // Address map, beat/wait terminal counts and next read-assembly value
   always_comb begin
      word_idx  = SRAM_AW'((address - WORD_W'(BASE_ADDR)) >> 2);
      beat_end  = (wait_cnt == WCW'(WAIT_CYC));
      last_beat = (beat_cnt == BCW'(BEATS - 1));
      dq_ext    = WORD_W'(SRAM_DQ);
      rd_next   = (rbuf >> SRAM_DW) | (dq_ext << (WORD_W - SRAM_DW));
   end

   // ready drops combinationally in the same cycle a request shows up in IDLE
   always_comb begin
      ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);
   end

   // Only the active write beat drives the bus. The lowest slice of wbuf is the current beat.
   assign SRAM_DQ   = SRAM_WE_N ? {SRAM_DW{1'bz}} : wbuf[SRAM_DW-1:0];
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

   // Controller FSM. Strobes and SRAM address are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         beat_cnt  <= '0;
         op_wr     <= 1'b0;
         wbuf      <= '0;
         rbuf      <= '0;
         rd_data   <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_CE_N <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (rd_en || wr_en) begin
                  state     <= ACCESS;
                  op_wr     <= wr_en;            // store wins if both are set
                  wbuf      <= wr_data;
                  wait_cnt  <= '0;
                  beat_cnt  <= '0;
                  SRAM_ADDR <= SRAM_AW'(word_idx * SRAM_AW'(BEATS));
                  SRAM_CE_N <= 1'b0;
                  SRAM_WE_N <= !wr_en;
                  SRAM_OE_N <= wr_en;
               end
            end
            ACCESS: begin
               if (!beat_end) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end else begin
                  wait_cnt <= '0;
                  if (!op_wr) rbuf <= rd_next;
                  if (last_beat) begin
                     state     <= DONE;
                     SRAM_CE_N <= 1'b1;
                     SRAM_WE_N <= 1'b1;
                     SRAM_OE_N <= 1'b1;
                     if (!op_wr) rd_data <= rd_next;
                  end else begin
                     beat_cnt  <= beat_cnt + 1'b1;
                     SRAM_ADDR <= SRAM_ADDR + 1'b1;
                     wbuf      <= wbuf >> SRAM_DW;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl_param.sv
// Bench for sram_ctrl_param. The default configuration runs a vector table,
// a mid-store reset and random traffic against a word-level reference. A 16/16 zero-wait
// instance covers back-to-back single-beat accesses.
module tb_sram_ctrl_param;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- default instance (32/16, 1 wait, base 1024) ----------------
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [31:0] address = '0, wr_data = '0;
   logic [31:0] rd_data;
   logic        ready;
   wire  [15:0] dq;
   logic [17:0] sa;
   logic        we_n, oe_n, ce_n, ub_n, lb_n;

   sram_ctrl_param dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
      .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .SRAM_DQ(dq),
      .SRAM_ADDR(sa), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
   );

   logic [15:0] mem [0:262143];
   assign dq = (!ce_n && !oe_n) ? mem[sa] : 16'hzzzz;
   always @(posedge clk) if (!ce_n && !we_n) mem[sa] <= dq;

   // ---------------- 16/16 instance, no wait states, base 0 ----------------
   logic        rd16 = 1'b0, wr16 = 1'b0;
   logic [15:0] a16 = '0, wd16 = '0;
   logic [15:0] rdd16;
   logic        rdy16;
   wire  [15:0] dq16;
   logic [17:0] sa16;
   logic        we16, oe16, ce16, ub16, lb16;

   sram_ctrl_param #(.WORD_W(16), .SRAM_DW(16), .SRAM_AW(18), .WAIT_CYC(0), .BASE_ADDR(0)) dut16 (
      .clk(clk), .rst(rst), .rd_en(rd16), .wr_en(wr16), .address(a16),
      .wr_data(wd16), .rd_data(rdd16), .ready(rdy16), .SRAM_DQ(dq16),
      .SRAM_ADDR(sa16), .SRAM_WE_N(we16), .SRAM_OE_N(oe16), .SRAM_CE_N(ce16),
      .SRAM_UB_N(ub16), .SRAM_LB_N(lb16)
   );

   logic [15:0] mem16 [0:262143];
   assign dq16 = (!ce16 && !oe16) ? mem16[sa16] : 16'hzzzz;
   always @(posedge clk) if (!ce16 && !we16) mem16[sa16] <= dq16;

   // ---------------- reference model ----------------
   logic [31:0] ref_words [int unsigned];
   logic [31:0] written [$];
   logic [31:0] last_rd = '0;

   function automatic int unsigned widx(input logic [31:0] a);
      return ((a - 32'd1024) >> 2) & 32'h3FFFF;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One access on the default instance, presented at posedge+1 of cycle 0.
   // Checks every cycle through DONE, then drops the request for cycle 6.
   task automatic run_acc(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
      int unsigned base;
      int unsigned beat;
      logic [31:0] slice;
      base = widx(a);
      rd_en = rd; wr_en = wr; address = a; wr_data = wd;
      @(negedge clk);
      chk($sformatf("a%0h c0 ready", a), ready, 0);
      chk($sformatf("a%0h c0 ce_n", a), ce_n, 1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         beat  = (c - 1) / 2;
         slice = (wd >> (16 * beat)) & 32'hFFFF;
         chk($sformatf("a%0h c%0d ready", a, c), ready, 0);
         chk($sformatf("a%0h c%0d ce_n", a, c), ce_n, 0);
         chk($sformatf("a%0h c%0d addr", a, c), sa, (base * 2 + beat) & 32'h3FFFF);
         if (wr) begin
            chk($sformatf("a%0h c%0d we_n", a, c), we_n, 0);
            chk($sformatf("a%0h c%0d oe_n", a, c), oe_n, 1);
            chk($sformatf("a%0h c%0d dq", a, c), dq, slice);
         end else begin
            chk($sformatf("a%0h c%0d oe_n", a, c), oe_n, 0);
            chk($sformatf("a%0h c%0d we_n", a, c), we_n, 1);
         end
      end
      @(negedge clk);
      chk($sformatf("a%0h c5 ready", a), ready, 1);
      chk($sformatf("a%0h c5 strobes", a), {ce_n, we_n, oe_n}, 3'b111);
      chk($sformatf("a%0h c5 rd_data", a), rd_data, exp_rd);
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   // Table access plus reference bookkeeping
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
      run_acc(rd, wr, a, wd, exp_rd);
      if (wr) begin
         ref_words[widx(a)] = wd;
         written.push_back(a & 32'hFFFF_FFFC);
      end else begin
         last_rd = exp_rd;
      end
   endtask

   typedef struct {
      bit          rd;
      bit          wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl [8];

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] e;
      bit          both;

      tbl[0] = '{0, 1, 32'd1028, 32'hDEADBEEF, 32'h0};
      tbl[1] = '{1, 0, 32'd1028, 32'h0,        32'hDEADBEEF};
      tbl[2] = '{0, 1, 32'd2000, 32'h55AA55AA, 32'hDEADBEEF};   // store keeps rd_data
      tbl[3] = '{1, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF};   // both set: store
      tbl[4] = '{1, 0, 32'd1032, 32'h0,        32'h12345678};
      tbl[5] = '{0, 1, 32'd1020, 32'hCAFEF00D, 32'h12345678};   // below base: wraps
      tbl[6] = '{1, 0, 32'd1020, 32'h0,        32'hCAFEF00D};
      tbl[7] = '{1, 0, 32'd2002, 32'h0,        32'h55AA55AA};   // low bits ignored

      // reset state
      @(negedge clk);
      chk("rst ready", ready, 1);
      chk("rst strobes", {ce_n, we_n, oe_n}, 3'b111);
      chk("rst addr", sa, 0);
      chk("rst rd_data", rd_data, 0);
      chk("byte enables", {ub_n, lb_n, ub16, lb16}, 4'b0000);
      chk("rst16 ready", rdy16, 1);
      rst = 1'b0;
      @(posedge clk); #1;

      // vector table
      for (int i = 0; i < 8; i++)
         do_op(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].exp_rd);
      chk("wrap lo word", mem[262142], 16'hF00D);
      chk("wrap hi word", mem[262143], 16'hCAFE);

      // reset in the middle of a store: beat 1 must never reach the SRAM
      rd_en = 1'b0; wr_en = 1'b1; address = 32'd1028; wr_data = 32'h11112222;
      @(negedge clk);                        // cycle 0
      @(negedge clk);                        // cycle 1
      chk("mid-rst pre we_n", we_n, 0);
      chk("mid-rst pre dq", dq, 16'h2222);
      @(posedge clk); #2;                    // inside cycle 2
      wr_en = 1'b0; rst = 1'b1;
      #1;
      chk("mid-rst ready", ready, 1);
      chk("mid-rst strobes", {ce_n, we_n, oe_n}, 3'b111);
      chk("mid-rst rd_data", rd_data, 0);
      chk("mid-rst addr", sa, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid-rst beat0 word", mem[2], 16'h2222);
      chk("mid-rst beat1 untouched", mem[3], 16'hDEAD);
      ref_words[widx(32'd1028)] = 32'hDEAD2222;
      last_rd = 32'h0;
      do_op(1, 0, 32'd1028, 32'h0, 32'hDEAD2222);

      // random traffic against the word-level reference
      for (int i = 0; i < 40; i++) begin
         if (written.size() > 0 && $urandom_range(0, 1) == 1) begin
            a = written[$urandom_range(0, written.size() - 1)] + $urandom_range(0, 3);
            e = ref_words[widx(a)];
            do_op(1, 0, a, $urandom, e);
         end else begin
            if ($urandom_range(0, 9) == 0)
               a = 32'd1024 - 4 * $urandom_range(1, 8);
            else
               a = 32'd1024 + 4 * $urandom_range(0, 200) + $urandom_range(0, 3);
            wd   = $urandom;
            both = ($urandom_range(0, 3) == 0);
            do_op(both, 1, a, wd, last_rd);
         end
      end

      // 16/16 zero-wait instance: store, then back-to-back load and store
      wr16 = 1'b1; a16 = 16'd0; wd16 = 16'hA5C3;
      @(negedge clk);
      chk("w16 c0 ready", rdy16, 0);
      @(negedge clk);
      chk("w16 c1 we_n", we16, 0);
      chk("w16 c1 dq", dq16, 16'hA5C3);
      @(negedge clk);
      chk("w16 c2 ready", rdy16, 1);
      @(posedge clk); #1;
      wr16 = 1'b0; rd16 = 1'b1; a16 = 16'd0;
      @(negedge clk);
      chk("r16 c0 ready", rdy16, 0);
      @(negedge clk);
      chk("r16 c1 ready", rdy16, 0);
      chk("r16 c1 oe_n", oe16, 0);
      chk("r16 c1 addr", sa16, 0);
      @(negedge clk);
      chk("r16 c2 ready", rdy16, 1);
      chk("r16 c2 rd_data", rdd16, 16'hA5C3);
      @(posedge clk); #1;
      rd16 = 1'b0; wr16 = 1'b1; a16 = 16'd4; wd16 = 16'h1357;
      @(negedge clk);
      chk("b2b c0 ready", rdy16, 0);
      @(negedge clk);
      chk("b2b c1 ready", rdy16, 0);
      chk("b2b c1 we_n", we16, 0);
      chk("b2b c1 addr", sa16, 1);
      chk("b2b c1 dq", dq16, 16'h1357);
      @(negedge clk);
      chk("b2b c2 ready", rdy16, 1);
      chk("b2b c2 rd_data", rdd16, 16'hA5C3);
      @(posedge clk); #1;
      wr16 = 1'b0;
      @(posedge clk); #1;
      chk("b2b sram word", mem16[1], 16'h1357);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
